clock_manager: RTL and testbench

CLOCK_MANAGER -- requirements
Module: clock_manager

---
 rtl/clock_manager.sv | 163 ++++++++++++++++
 tb/tb_clock_manager.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_manager.sv
`default_nettype none
// ============================================================================
// Module   : clock_manager
// Brief    : PLL-lock qualified reset sequencer with per-channel clock enables.
// Revision : 1.0
// ============================================================================
module clock_manager #(
    parameter int NUM_CH      = 4,
    parameter int DIV_WIDTH   = 16,
    parameter int LOCK_FILTER = 16,
    parameter int HOLD_CYCLES = 1024,
    parameter int DIV_DEFAULT = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 locked,
    input  logic                 div_load,
    input  logic [3:0]           div_channel,
    input  logic [DIV_WIDTH-1:0] div_value,
    output logic                 reset_out,
    output logic                 ready,
    output logic [NUM_CH-1:0]    strobe,
    output logic [7:0]           lock_loss_count
);

    localparam int FILT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [FILT_W-1:0]    C_FILT_LAST = FILT_W'(LOCK_FILTER - 1);
    localparam logic [HOLD_W-1:0]    C_HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DIV_WIDTH-1:0] C_DIV_DEF   = DIV_WIDTH'(DIV_DEFAULT);
    localparam logic [DIV_WIDTH-1:0] C_DIV_ONE   = DIV_WIDTH'(1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    logic              meta_q, meta_d;
    logic              locked_s_q, locked_s_d;
    state_t            state_q, state_d;
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]        loss_cnt_q, loss_cnt_d;
    logic              run_stay;

    // Two-flop synchroniser for the asynchronous lock indication
    always_comb begin
        meta_d     = locked;
        locked_s_d = meta_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q     <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            meta_q     <= meta_d;
            locked_s_q <= locked_s_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        filt_cnt_d = '0;
        hold_cnt_d = '0;
        loss_cnt_d = loss_cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                if (locked_s_q) begin
                    state_d = FILTER;
                end
            end
            FILTER: begin
                if (!locked_s_q) begin
                    state_d = WAIT_LOCK;
                end else if (filt_cnt_q == C_FILT_LAST) begin
                    state_d = HOLD;
                end else begin
                    filt_cnt_d = filt_cnt_q + FILT_W'(1);
                end
            end
            HOLD: begin
                if (!locked_s_q) begin
                    state_d = WAIT_LOCK;
                end else if (hold_cnt_q == C_HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            RUN: begin
                if (!locked_s_q) begin
                    state_d = WAIT_LOCK;
                    if (loss_cnt_q != 8'hFF) begin
                        loss_cnt_d = loss_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= WAIT_LOCK;
            filt_cnt_q <= '0;
            hold_cnt_q <= '0;
            loss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            filt_cnt_q <= filt_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    // Channel counters only advance while RUN persists, so they read 0 on RUN entry
    assign run_stay = (state_q == RUN) && (state_d == RUN);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_WIDTH-1:0] div_q, div_d;
        logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
        logic                 load_hit;

        always_comb begin
            load_hit = div_load && (div_channel == 4'(i));
            div_d    = div_q;
            cnt_d    = '0;
            if (load_hit) begin
                div_d = div_value;
            end else if (run_stay && (div_q != '0)) begin
                if (cnt_q == div_q - C_DIV_ONE) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + C_DIV_ONE;
                end
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                div_q <= C_DIV_DEF;
                cnt_q <= '0;
            end else begin
                div_q <= div_d;
                cnt_q <= cnt_d;
            end
        end

        assign strobe[i] = (state_q == RUN) && (div_q != '0) && (cnt_q == div_q - C_DIV_ONE);
    end : g_ch

    assign reset_out       = (state_q != RUN);
    assign ready           = (state_q == RUN);
    assign lock_loss_count = loss_cnt_q;

endmodule : clock_manager
`default_nettype wire

// File: tb/tb_clock_manager.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_clock_manager
// Brief    : Randomised scoreboard bench for clock_manager against a lock-streak model.
// Revision : 1.0
// ============================================================================
module tb_clock_manager;

    localparam int NUM_CH      = 2;
    localparam int DIV_WIDTH   = 4;
    localparam int LOCK_FILTER = 4;
    localparam int HOLD_CYCLES = 8;
    localparam int DIV_DEFAULT = 2;
    localparam int RUN_AFTER   = LOCK_FILTER + HOLD_CYCLES;
    localparam int MAX_T       = 20000;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 locked = 1'b0;
    logic                 div_load = 1'b0;
    logic [3:0]           div_channel = '0;
    logic [DIV_WIDTH-1:0] div_value = '0;
    logic                 reset_out;
    logic                 ready;
    logic [NUM_CH-1:0]    strobe;
    logic [7:0]           lock_loss_count;

    always #5 clock = ~clock;

    clock_manager #(
        .NUM_CH      (NUM_CH),
        .DIV_WIDTH   (DIV_WIDTH),
        .LOCK_FILTER (LOCK_FILTER),
        .HOLD_CYCLES (HOLD_CYCLES),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .locked          (locked),
        .div_load        (div_load),
        .div_channel     (div_channel),
        .div_value       (div_value),
        .reset_out       (reset_out),
        .ready           (ready),
        .strobe          (strobe),
        .lock_loss_count (lock_loss_count)
    );

    typedef struct {
        bit              ro;
        bit              rdy;
        bit [NUM_CH-1:0] stb;
        int              llc;
        int              t;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: the system is in RUN once the synchronised lock has been
    // continuously high for more than LOCK_FILTER+HOLD_CYCLES sampled edges.
    bit lk_hist[MAX_T];
    int t      = 0;
    int r_last = 0;
    int streak = 0;
    int losses = 0;
    int d_m[NUM_CH];
    int origin[NUM_CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v, input int tt);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, tt, act, exp_v);
        end
    endtask

    task automatic cycle(input bit rst, input bit lk, input bit ld, input int ch, input int val);
        bit   pre_ls;
        bit   pre_run;
        bit   run_now;
        exp_t e;
        @(negedge clock);
        reset       = rst;
        locked      = lk;
        div_load    = ld;
        div_channel = ch[3:0];
        div_value   = val[DIV_WIDTH-1:0];
        t++;
        lk_hist[t] = lk;
        pre_ls  = (t - 2 >= r_last + 1) ? lk_hist[t-2] : 1'b0;
        pre_run = (streak > RUN_AFTER);
        if (rst) begin
            streak = 0;
            losses = 0;
            r_last = t;
            for (int i = 0; i < NUM_CH; i++) begin
                d_m[i]    = DIV_DEFAULT;
                origin[i] = t;
            end
        end else begin
            if (pre_ls) begin
                streak = (streak > RUN_AFTER) ? RUN_AFTER + 1 : streak + 1;
            end else begin
                if (pre_run && losses < 255) losses++;
                streak = 0;
            end
            if (streak > RUN_AFTER && !pre_run) begin
                for (int i = 0; i < NUM_CH; i++) origin[i] = t;
            end
            if (ld && ch < NUM_CH) begin
                d_m[ch]    = val;
                origin[ch] = t;
            end
        end
        run_now = (streak > RUN_AFTER);
        e.ro  = !run_now;
        e.rdy = run_now;
        e.llc = losses;
        e.t   = t;
        for (int i = 0; i < NUM_CH; i++) begin
            e.stb[i] = run_now && (d_m[i] != 0) && (((t - origin[i]) % d_m[i]) == d_m[i] - 1);
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit lk);
        for (int k = 0; k < n; k++) cycle(1'b0, lk, 1'b0, 0, 0);
    endtask

    // Monitor: outputs are valid every cycle, compared one cycle-record at a time
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("reset_out",       {31'b0, reset_out}, {31'b0, e.ro},  e.t);
                check("ready",           {31'b0, ready},     {31'b0, e.rdy}, e.t);
                check("strobe",          {30'b0, strobe},    {30'b0, e.stb}, e.t);
                check("lock_loss_count", {24'b0, lock_loss_count}, e.llc,    e.t);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int rnd_ch;
        int rnd_val;
        // Reset, then steady lock up to RUN with default divisors
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, 0, 0);
        idle(30, 1'b1);

        // Lose lock, then glitch while the filter is at its last count
        idle(5, 1'b0);
        idle(4, 1'b1);
        idle(1, 1'b0);
        idle(25, 1'b1);

        // Divisor writes on channel 1 while running
        cycle(1'b0, 1'b1, 1'b1, 1, 5);
        idle(16, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1, 0);
        idle(8, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1, 1);
        idle(6, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 3, 9);
        idle(6, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 0, 3);
        idle(10, 1'b1);

        // Repeated lock losses, enough to saturate the counter
        for (int n = 0; n < 300; n++) begin
            idle($urandom_range(1, 2), 1'b0);
            idle($urandom_range(16, 18), 1'b1);
        end

        // Reset in RUN after loading channel 0
        cycle(1'b0, 1'b1, 1'b1, 0, 7);
        idle(10, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 0, 0);
        idle(24, 1'b1);

        // Randomised traffic
        for (int k = 0; k < 2500; k++) begin
            rnd_ch  = $urandom_range(0, 3);
            rnd_val = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 15);
            cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 49) != 0,
                  $urandom_range(0, 7) == 0,
                  rnd_ch, rnd_val);
        end
        idle(3, 1'b1);

        repeat (3) @(posedge clock);
        #2;
        check("queue_drain", exp_q.size(), 0, t);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_clock_manager
`default_nettype wire
